// File: rtl/rlc_pkg.sv
// rtl/rlc_pkg.sv - shared widths and scheduler state encoding
package rlc_pkg;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // first set request bit searching upward from ptr+1, wrapping at N
  always_comb begin
    int          c;
    logic [IW-1:0] cidx;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int k = 1; k <= N; k++) begin
      c    = (int'(ptr) + k) % N;
      cidx = IW'(c);
      if (!valid && req[cidx]) begin
        valid = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/rlc_decode_sched.sv
// rtl/rlc_decode_sched.sv - round-robin sharing of one rlc decoder between requesters
module rlc_decode_sched #(
  parameter int N_REQ  = 4,
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           job_req,
  input  logic [N_REQ*LEN_W-1:0]     job_len,
  output logic [N_REQ-1:0]           job_gnt,
  output logic [N_REQ-1:0]           job_done,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [DATA_W-1:0]          dec_in_data,
  output logic                       dec_in_valid,
  input  logic                       dec_in_ready,
  input  logic [DATA_W-1:0]          dec_out,
  input  logic                       dec_out_valid,
  output logic                       dec_out_ready,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       err_stray
);

  import rlc_pkg::*;

  localparam int OW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_ptr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [N_REQ-1:0]   gnt_q;

  logic [OW-1:0]      pick_idx;
  logic               pick_valid;
  logic [LEN_W-1:0]   len_pick;
  logic               out_hs;
  logic               last_hs;

  rr_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_rr_pick (
    .req   (job_req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign len_pick = job_len[pick_idx*LEN_W +: LEN_W];
  assign out_hs   = (state_q == ST_BUSY) && dec_out_valid && rsp_ready[owner_q];
  // cnt only reaches len_q-1 before the job ends, so it never wraps
  assign last_hs  = out_hs && (cnt_q == len_q - 1'b1);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next state: requests only matter in IDLE; a zero-length job skips BUSY
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_valid) state_d = (len_pick != '0) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (last_hs)    state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // job bookkeeping: latch owner/length at grant, count delivered words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= '0;
      rr_ptr_q <= OW'(N_REQ - 1);
      len_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
    end else begin
      gnt_q <= '0;
      if (state_q == ST_IDLE && pick_valid) begin
        owner_q  <= pick_idx;
        rr_ptr_q <= pick_idx;
        len_q    <= len_pick;
        cnt_q    <= '0;
        gnt_q    <= ONE_HOT0 << pick_idx;
      end else if (out_hs) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // datapath mux: owner is wired straight through while BUSY, otherwise parked
  always_comb begin
    dec_in_data   = '0;
    dec_in_valid  = 1'b0;
    req_ready     = '0;
    rsp_data      = '0;
    rsp_valid     = '0;
    dec_out_ready = 1'b1;
    job_done      = '0;
    err_stray     = 1'b0;
    if (state_q == ST_BUSY) begin
      dec_in_data        = req_data[owner_q*DATA_W +: DATA_W];
      dec_in_valid       = req_valid[owner_q];
      req_ready[owner_q] = dec_in_ready;
      rsp_data           = dec_out;
      rsp_valid[owner_q] = dec_out_valid;
      dec_out_ready      = rsp_ready[owner_q];
    end else begin
      err_stray = dec_out_valid;
      if (state_q == ST_DONE) job_done[owner_q] = 1'b1;
    end
  end

  assign busy    = (state_q == ST_BUSY);
  assign owner   = owner_q;
  assign job_gnt = gnt_q;

endmodule

// File: tb/tb_rlc_decode_sched.sv
// tb/tb_rlc_decode_sched.sv - directed bench for rlc_decode_sched
module tb_rlc_decode_sched;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    job_req;
  logic [63:0]   job_len;
  logic [3:0]    job_gnt;
  logic [3:0]    job_done;
  logic [127:0]  req_data;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [31:0]   dec_in_data;
  logic          dec_in_valid;
  logic          dec_in_ready;
  logic [31:0]   dec_out;
  logic          dec_out_valid;
  logic          dec_out_ready;
  logic          busy;
  logic [1:0]    owner;
  logic          err_stray;

  int n_checks = 0;
  int n_errors = 0;

  rlc_decode_sched #(
    .N_REQ  (4),
    .LEN_W  (16),
    .DATA_W (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .job_req       (job_req),
    .job_len       (job_len),
    .job_gnt       (job_gnt),
    .job_done      (job_done),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .dec_in_data   (dec_in_data),
    .dec_in_valid  (dec_in_valid),
    .dec_in_ready  (dec_in_ready),
    .dec_out       (dec_out),
    .dec_out_valid (dec_out_valid),
    .dec_out_ready (dec_out_ready),
    .busy          (busy),
    .owner         (owner),
    .err_stray     (err_stray)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    int n;
    g = '0;
    n = 0;
    while (g == 4'b0 && n < 20) begin
      tick;
      g = job_gnt;
      n++;
    end
    if (g == 4'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL gnt_timeout: got no grant within %0d cycles", n);
    end
  endtask

  logic [3:0] g;
  logic [4:0] bp;

  initial begin
    reset = 1'b1; job_req = '0; job_len = '0; req_data = '0; req_valid = '0;
    rsp_ready = '0; dec_in_ready = 1'b0; dec_out = '0; dec_out_valid = 1'b0;
    tick; tick;

    // reset state
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_gnt", job_gnt, 0);
    check("rst_done", job_done, 0);
    check("rst_dec_out_ready", dec_out_ready, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_dec_in_valid", dec_in_valid, 0);
    reset = 1'b0;

    // single job: requester 1, four decoded words from one encoded word
    job_req = 4'b0010; job_len[16 +: 16] = 16'd4;
    tick;
    check("single_gnt", job_gnt, 4'b0010);
    check("single_busy", busy, 1);
    check("single_owner", owner, 1);
    job_req = '0;
    req_data[32 +: 32] = 32'hCAFE_0001; req_valid = 4'b0010; dec_in_ready = 1'b1;
    #1;
    check("single_in_valid", dec_in_valid, 1);
    check("single_in_data", dec_in_data, 32'hCAFE_0001);
    check("single_req_ready", req_ready, 4'b0010);
    tick;
    check("single_gnt_pulse", job_gnt, 0);
    req_valid = '0; rsp_ready = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      dec_out_valid = 1'b1; dec_out = 32'hD000_0000 + i;
      #1;
      check("single_rsp_valid", rsp_valid, 4'b0010);
      check("single_rsp_data", rsp_data, 32'hD000_0000 + i);
      check("single_done_early", job_done, 0);
      tick;
    end
    dec_out_valid = 1'b0;
    #1;
    check("single_done", job_done, 4'b0010);
    check("single_done_rsp", rsp_valid, 0);
    check("single_done_req_ready", req_ready, 0);
    tick;
    check("single_idle_done", job_done, 0);
    check("single_idle_busy", busy, 0);

    // fairness: all four hold len-1 requests, fresh pointer after reset
    reset = 1'b1; tick; reset = 1'b0;
    job_len = {4{16'd1}}; job_req = 4'b1111; rsp_ready = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_gnt(g);
      check("fair_gnt", g, 4'b0001 << (j % 4));
      dec_out_valid = 1'b1;
      #1;
      check("fair_rsp_valid", rsp_valid, g);
      tick;
      dec_out_valid = 1'b0;
      #1;
      check("fair_done", job_done, g);
      tick;
    end
    job_req = '0;

    // backpressure: requester 2, len 3, rsp_ready pattern 1,0,0,1,1
    job_req = 4'b0100; job_len[32 +: 16] = 16'd3;
    wait_gnt(g);
    check("bp_gnt", g, 4'b0100);
    job_req = '0; dec_out_valid = 1'b1;
    bp = 5'b11001;
    for (int c = 0; c < 5; c++) begin
      rsp_ready = {1'b0, bp[c], 2'b00};
      #1;
      check("bp_dec_out_ready", dec_out_ready, bp[c]);
      check("bp_rsp_valid", rsp_valid, 4'b0100);
      check("bp_busy", busy, 1);
      check("bp_no_done", job_done, 0);
      tick;
    end
    dec_out_valid = 1'b0;
    #1;
    check("bp_done", job_done, 4'b0100);
    tick;

    // zero length: requester 3, grant and done share the DONE cycle
    job_req = 4'b1000; job_len[48 +: 16] = 16'd0; req_valid = 4'b1000; dec_in_ready = 1'b1;
    tick;
    check("zero_gnt", job_gnt, 4'b1000);
    check("zero_done", job_done, 4'b1000);
    check("zero_in_valid", dec_in_valid, 0);
    check("zero_req_ready", req_ready, 0);
    check("zero_busy", busy, 0);
    job_req = '0; req_valid = '0;
    tick;
    check("zero_after_gnt", job_gnt, 0);
    check("zero_after_done", job_done, 0);

    // stray decoder output while IDLE
    rsp_ready = '0; dec_out_valid = 1'b1;
    #1;
    check("stray_err", err_stray, 1);
    check("stray_ready", dec_out_ready, 1);
    check("stray_rsp_valid", rsp_valid, 0);
    tick;
    dec_out_valid = 1'b0;
    #1;
    check("stray_err_clear", err_stray, 0);

    // reset mid-job: requester 1, len 5, reset after 2 outputs
    job_req = 4'b0010; job_len[16 +: 16] = 16'd5;
    wait_gnt(g);
    check("mid_gnt", g, 4'b0010);
    job_req = '0; rsp_ready = 4'b0010; dec_out_valid = 1'b1;
    tick; tick;
    check("mid_busy", busy, 1);
    dec_out_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_done", job_done, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_dec_out_ready", dec_out_ready, 1);
    check("mid_rst_gnt", job_gnt, 0);
    tick;
    check("mid_rst_done_held", job_done, 0);
    reset = 1'b0;
    job_len = {4{16'd1}}; job_req = 4'b1111;
    wait_gnt(g);
    check("mid_after_gnt", g, 4'b0001);
    check("mid_after_owner", owner, 0);
    job_req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
